vpu_cfg_sched: RTL and testbench
================================

Name: vpu_cfg_sched

Overview:
- Sequences vector CSR and vset[i]vl[i] micro-ops from VPU ISSUE into the VPU configuration CSR unit. That unit has a single-cycle, stateful port with no handshake.
- Holds each config op until every in-flight vector uop has retired, so no executing uop observes a changed vtype/vl/vxrm.
- Shares the CSR port with fixed-point units that need to set vxsat.
- Returns the CSR read data to COMMIT through a valid/ready handshake.

Parameters:
- MAX_OUTSTANDING, 8, maximum number of in-flight non-config vector uops.
- NUM_RETIRE, 2, number of per-cycle retire pulses (one per execution lane group).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_valid_i  in  1  config uop offered by ISSUE.
- cfg_ready_o  out  1  config uop accepted.
- cfg_entry_i  in  VPU_uOP_t  config uop; mode.cfg.csr_op and rs1.xval are used.
- vec_valid_i  in  1  non-config vector uop offered by ISSUE.
- vec_ready_o  out  1  vector uop accepted.
- retire_i  in  NUM_RETIRE  one pulse per vector uop retired this cycle.
- sat_valid_i  in  1  a fixed-point uop saturated; vxsat must be set.
- VCFG_valid_o  out  1  drive the CSR unit this cycle.
- VCFG_entry_o  out  VPU_uOP_t  uop presented to the CSR unit.
- VCFG_read_valid_i  in  1  CSR unit read valid.
- VCFG_read_data_i  in  32  CSR unit read data.
- resp_valid_o  out  1  result available for COMMIT.
- resp_ready_i  in  1  COMMIT accepts the result.
- resp_data_o  out  32  CSR read value or new vl.
- outstanding_o  out  CNT_W  current in-flight vector uop count.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset: asynchronous, active-low. All state clears while rst_ni=0: FSM=IDLE, counter=0, sat_pend=0, entry register=0, resp_data=0. All valid/ready outputs are 0 during reset.
- FSM states: IDLE, DRAIN, EXEC, RESP.
- cfg_ready_o = (state==IDLE). On a handshake, cfg_entry_i is registered and the FSM goes IDLE->DRAIN.
- DRAIN -> EXEC when counter==0, sat_pend==0, and no sat injection this cycle. Otherwise the FSM stays in DRAIN, with no timeout.
- EXEC lasts exactly one cycle:
  - VCFG_valid_o=1 and VCFG_entry_o = registered entry.
  - VCFG_read_data_i is captured into resp_data.
  - The FSM goes to RESP.
- RESP: resp_valid_o=1 and resp_data_o is held stable until resp_ready_i; then the FSM returns to IDLE. resp_data_o is 0 outside RESP.
- Minimum latency: handshake at cycle t, DRAIN at t+1, EXEC at t+2, resp_valid at t+3.
- Outstanding counter:
  - Increments by 1 on a vec_valid_i & vec_ready_o handshake.
  - Decrements by popcount(retire_i).
  - Both in the same cycle give a net change.
  - A decrement below 0 is illegal. It is guarded by an assertion and the counter saturates at 0.
- vec_ready_o = (state==IDLE) & (counter < MAX_OUTSTANDING) & !(cfg_valid_i). A pending config op blocks younger vector uops (program order). A simultaneous cfg and vec offer: cfg wins.
- vxsat injection:
  - sat_valid_i sets sticky sat_pend.
  - When state!=EXEC and sat_pend|sat_valid_i, the block drives VCFG_valid_o=1 with a synthesized uop: csr_op=CFG_VXSAT_SET, rs1.xval=32'd1, other fields 0. sat_pend then clears.
  - The injected read data is discarded and never reaches resp.
  - A sat_valid_i arriving during EXEC is held in sat_pend and injected the next cycle.
- Counter full: vec_ready_o=0. It reopens in the same cycle that a retire makes counter<MAX (the combinational path from retire_i is allowed).
- A reset mid-operation (any state) drops the held config op and any response. ISSUE must replay it.
- VCFG_valid_o is asserted at most once per cycle, either EXEC or injection, never both.

Decomposition:
- Shared package:
  - VPU_uOP_t
  - CFG_VXSAT_SET and other csr_op enums
  - a new VCFG_SCHED_STATE_e enum
  - a MAX_OUTSTANDING default localparam
- One natural sub-module, vpu_cfg_outstanding_cnt: up/down counter with a popcount decrement, full flag and zero flag.

Test Plan:
- Idle config read:
  - Stimulus: counter=0; offer CFG_VL_READ at cycle 0; VCFG_read_data_i=32'd16; resp_ready_i=1.
  - Required: VCFG_valid_o at cycle 2, resp_valid_o at cycle 3 with resp_data_o=16, back in IDLE at cycle 4.
- Drain wait:
  - Stimulus: issue 3 vec uops, then CFG_VSETVL; retire one uop per cycle.
  - Required: VCFG_valid_o stays 0 until the cycle after outstanding_o reaches 0; vec_ready_o=0 throughout.
- Full:
  - Stimulus: issue 8 vec uops with no retire.
  - Required: vec_ready_o=0 and outstanding_o=8. Retire_i=2'b11 gives outstanding_o=6 next cycle with vec_ready_o=1.
- Sat arbitration:
  - Stimulus: sat_valid_i pulses in the same cycle as the last retire while in DRAIN.
  - Required: the injected CFG_VXSAT_SET with xval=1 appears before the EXEC cycle; resp data comes from the EXEC read only.
- Response backpressure:
  - Stimulus: resp_ready_i=0 for 5 cycles.
  - Required: resp_valid_o and resp_data_o are stable, cfg_ready_o=0, then IDLE one cycle after ready.
- Async reset in EXEC:
  - Stimulus: assert rst_ni=0 mid-cycle.
  - Required: VCFG_valid_o, resp_valid_o and cfg_ready_o go to 0 immediately; outstanding_o=0.

Source files
------------

// File: rtl/vpu_cfg_sched_pkg.sv
// vpu_cfg_sched_pkg
//   Shared types for the VPU configuration scheduler: the vector micro-op
//   layout, the CSR operation codes, the scheduler state encoding and the
//   default sizing.
package vpu_cfg_sched_pkg;

    localparam int MAX_OUTSTANDING_DEF = 8;
    localparam int NUM_RETIRE_DEF      = 2;

    typedef enum logic [2:0] {
        CFG_NONE      = 3'd0,
        CFG_VSETVL    = 3'd1,
        CFG_VSETVLI   = 3'd2,
        CFG_VSETIVLI  = 3'd3,
        CFG_VL_READ   = 3'd4,
        CFG_CSR_READ  = 3'd5,
        CFG_CSR_WRITE = 3'd6,
        CFG_VXSAT_SET = 3'd7
    } cfg_csr_op_e;

    typedef struct packed {
        cfg_csr_op_e csr_op;
        logic [11:0] csr_addr;
    } cfg_mode_t;

    typedef struct packed {
        cfg_mode_t cfg;
    } vpu_mode_t;

    typedef struct packed {
        logic [31:0] xval;
    } vpu_src_t;

    typedef struct packed {
        logic [5:0] tag;
        vpu_mode_t  mode;
        vpu_src_t   rs1;
        vpu_src_t   rs2;
    } VPU_uOP_t;

    typedef enum logic [1:0] {
        VCFG_IDLE  = 2'd0,
        VCFG_DRAIN = 2'd1,
        VCFG_EXEC  = 2'd2,
        VCFG_RESP  = 2'd3
    } VCFG_SCHED_STATE_e;

    // Micro-op the scheduler synthesizes to set vxsat on behalf of the
    // fixed-point units: only csr_op and rs1 are meaningful.
    function automatic VPU_uOP_t vxsat_set_uop();
        VPU_uOP_t u;
        u = '0;
        u.mode.cfg.csr_op = CFG_VXSAT_SET;
        u.rs1.xval        = 32'd1;
        return u;
    endfunction

endpackage

// File: rtl/vpu_cfg_sched_if.sv
// vpu_cfg_sched_if
//   Bundles the ISSUE, retire, saturation, CSR-unit and COMMIT signals of
//   the configuration scheduler.
//   slave  : scheduler side (vpu_cfg_sched)
//   master : surrounding pipeline side (ISSUE / EXEC lanes / CSR unit / COMMIT)
interface vpu_cfg_sched_if
    import vpu_cfg_sched_pkg::*;
#(
    parameter int NUM_RETIRE = NUM_RETIRE_DEF,
    parameter int CNT_W      = $clog2(MAX_OUTSTANDING_DEF + 1)
);
    logic                  cfg_valid_i;
    logic                  cfg_ready_o;
    VPU_uOP_t              cfg_entry_i;
    logic                  vec_valid_i;
    logic                  vec_ready_o;
    logic [NUM_RETIRE-1:0] retire_i;
    logic                  sat_valid_i;
    logic                  VCFG_valid_o;
    VPU_uOP_t              VCFG_entry_o;
    logic                  VCFG_read_valid_i;
    logic [31:0]           VCFG_read_data_i;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [31:0]           resp_data_o;
    logic [CNT_W-1:0]      outstanding_o;
    logic                  busy_o;

    modport slave (
        input  cfg_valid_i, cfg_entry_i, vec_valid_i, retire_i, sat_valid_i,
               VCFG_read_valid_i, VCFG_read_data_i, resp_ready_i,
        output cfg_ready_o, vec_ready_o, VCFG_valid_o, VCFG_entry_o,
               resp_valid_o, resp_data_o, outstanding_o, busy_o
    );

    modport master (
        output cfg_valid_i, cfg_entry_i, vec_valid_i, retire_i, sat_valid_i,
               VCFG_read_valid_i, VCFG_read_data_i, resp_ready_i,
        input  cfg_ready_o, vec_ready_o, VCFG_valid_o, VCFG_entry_o,
               resp_valid_o, resp_data_o, outstanding_o, busy_o
    );

endinterface

// File: rtl/vpu_cfg_outstanding_cnt.sv
// vpu_cfg_outstanding_cnt
//   Count of in-flight non-config vector uops.
//   clk, rst_n : clock, async active-low reset
//   inc        : one uop accepted this cycle
//   dec        : retire pulses, count drops by their popcount
//   count      : current registered count
//   full       : no room for another uop this cycle (same-cycle retires
//                already counted as freeing room)
//   zero       : registered count is zero
module vpu_cfg_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int NUM_RETIRE      = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic [NUM_RETIRE-1:0] dec,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  zero
);
    localparam int SUM_W = $clog2(MAX_OUTSTANDING + NUM_RETIRE + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] pop, sum;
    logic             underflow;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_RETIRE; i++) pop = pop + SUM_W'(dec[i]);
        sum       = SUM_W'(cnt_q) + SUM_W'(inc);
        underflow = pop > sum;
        // Retiring more than is in flight is a pipeline bug; clamp at zero.
        cnt_d     = underflow ? '0 : CNT_W'(sum - pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);
    // A retire in the same cycle always frees a slot, so the full condition
    // only holds when nothing retires.
    assign full  = (cnt_q >= CNT_W'(MAX_OUTSTANDING)) && (pop == '0);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !underflow);

endmodule

// File: rtl/vpu_cfg_sched.sv
// vpu_cfg_sched
//   Serializes vector configuration uops onto the single-cycle CSR unit port.
//   A config op waits until every in-flight vector uop has retired, then
//   drives the CSR unit for one cycle and hands the read data to COMMIT.
//   Fixed-point saturation events borrow the same port to set vxsat.
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : handshake/bus bundle (slave side)
module vpu_cfg_sched
    import vpu_cfg_sched_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int NUM_RETIRE      = NUM_RETIRE_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    vpu_cfg_sched_if.slave  bus
);
    VCFG_SCHED_STATE_e state, state_nxt;
    VPU_uOP_t          entry_q;
    logic [31:0]       resp_q;
    logic              sat_pend;

    logic              idle, cfg_ready, vec_ready, vec_hs, cfg_hs, sat_inject;
    logic              cnt_full, cnt_zero;
    logic [CNT_W-1:0]  cnt;
    VPU_uOP_t          vcfg_entry;

    vpu_cfg_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .NUM_RETIRE      (NUM_RETIRE),
        .CNT_W           (CNT_W)
    ) u_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (vec_hs),
        .dec   (bus.retire_i),
        .count (cnt),
        .full  (cnt_full),
        .zero  (cnt_zero)
    );

    // Valid/ready outputs are gated by reset so they drop the instant
    // rst_ni falls, not at the next edge.
    always_comb begin
        idle       = (state == VCFG_IDLE);
        cfg_ready  = rst_ni & idle;
        // A waiting config op is older than any vector uop offered with it.
        vec_ready  = rst_ni & idle & ~cnt_full & ~bus.cfg_valid_i;
        cfg_hs     = bus.cfg_valid_i & cfg_ready;
        vec_hs     = bus.vec_valid_i & vec_ready;
        // EXEC owns the port; any other cycle is free for a vxsat write.
        sat_inject = rst_ni & (state != VCFG_EXEC) & (sat_pend | bus.sat_valid_i);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            VCFG_IDLE:  if (cfg_hs) state_nxt = VCFG_DRAIN;
            // Pending vxsat writes go first so the config op sees final vxsat.
            VCFG_DRAIN: if (cnt_zero && !sat_pend && !bus.sat_valid_i)
                            state_nxt = VCFG_EXEC;
            VCFG_EXEC:  state_nxt = VCFG_RESP;
            VCFG_RESP:  if (bus.resp_ready_i) state_nxt = VCFG_IDLE;
            default:    state_nxt = VCFG_IDLE;
        endcase
    end

    always_comb begin
        vcfg_entry = '0;
        if (state == VCFG_EXEC) vcfg_entry = entry_q;
        else if (sat_inject)    vcfg_entry = vxsat_set_uop();
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= VCFG_IDLE;
            entry_q  <= '0;
            resp_q   <= '0;
            sat_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cfg_hs) entry_q <= bus.cfg_entry_i;
            // Only the EXEC read is kept; vxsat read data is dropped.
            if (state == VCFG_EXEC) resp_q <= bus.VCFG_read_data_i;
            sat_pend <= sat_inject ? 1'b0 : (sat_pend | bus.sat_valid_i);
        end
    end

    assign bus.cfg_ready_o   = cfg_ready;
    assign bus.vec_ready_o   = vec_ready;
    assign bus.VCFG_valid_o  = (rst_ni & (state == VCFG_EXEC)) | sat_inject;
    assign bus.VCFG_entry_o  = vcfg_entry;
    assign bus.resp_valid_o  = rst_ni & (state == VCFG_RESP);
    assign bus.resp_data_o   = (state == VCFG_RESP) ? resp_q : 32'd0;
    assign bus.outstanding_o = cnt;
    assign bus.busy_o        = ~idle;

    // The CSR unit answers in the same cycle it is driven.
    a_exec_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  (state == VCFG_EXEC) |-> bus.VCFG_read_valid_i);

endmodule

// File: tb/tb_vpu_cfg_sched.sv
// tb_vpu_cfg_sched
//   Directed scenarios with literal expectations followed by randomized
//   traffic; a reference model checks every DUT output on every negedge.
module tb_vpu_cfg_sched;
    import vpu_cfg_sched_pkg::*;

    localparam int MAXO = 8;
    localparam int NR   = 2;
    localparam int CW   = $clog2(MAXO + 1);

    logic clk   = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    vpu_cfg_sched_if #(.NUM_RETIRE(NR), .CNT_W(CW)) bus ();

    vpu_cfg_sched #(.MAX_OUTSTANDING(MAXO), .NUM_RETIRE(NR), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // CSR unit answers in the same cycle it is driven.
    assign bus.VCFG_read_valid_i = bus.VCFG_valid_o;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pop(input logic [NR-1:0] r);
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(r[i]);
        return c;
    endfunction

    function automatic VPU_uOP_t mk(input cfg_csr_op_e op, input logic [31:0] x);
        VPU_uOP_t u = '0;
        u.mode.cfg.csr_op = op;
        u.rs1.xval        = x;
        u.tag             = 6'($urandom);
        return u;
    endfunction

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 waiting for drain, 2 driving CSR unit, 3 result held
    int          m_phase, m_cnt;
    bit          m_sat;
    VPU_uOP_t    m_op;
    logic [31:0] m_resp;

    int          mc_p;
    bit          mc_inj, mc_vready, mc_vhs;
    VPU_uOP_t    mc_entry, mc_vx;

    always @(negedge clk) begin
        if (!rst_ni) begin
            chk("rst_cfg_ready",  bus.cfg_ready_o,   0);
            chk("rst_vec_ready",  bus.vec_ready_o,   0);
            chk("rst_vcfg_valid", bus.VCFG_valid_o,  0);
            chk("rst_resp_valid", bus.resp_valid_o,  0);
            chk("rst_resp_data",  bus.resp_data_o,   0);
            chk("rst_outstanding", bus.outstanding_o, 0);
            m_phase = 0; m_cnt = 0; m_sat = 0; m_op = '0; m_resp = '0;
        end else begin
            mc_p      = pop(bus.retire_i);
            mc_vready = (m_phase == 0) && !bus.cfg_valid_i && (m_cnt - mc_p < MAXO);
            mc_vhs    = mc_vready && bus.vec_valid_i;
            mc_inj    = (m_phase != 2) && (m_sat || bus.sat_valid_i);
            mc_vx     = '0;
            mc_vx.mode.cfg.csr_op = CFG_VXSAT_SET;
            mc_vx.rs1.xval        = 32'd1;
            mc_entry  = (m_phase == 2) ? m_op : (mc_inj ? mc_vx : VPU_uOP_t'('0));

            chk("cfg_ready",   bus.cfg_ready_o,   m_phase == 0);
            chk("vec_ready",   bus.vec_ready_o,   mc_vready);
            chk("vcfg_valid",  bus.VCFG_valid_o,  (m_phase == 2) || mc_inj);
            chk("vcfg_entry",  bus.VCFG_entry_o,  mc_entry);
            chk("resp_valid",  bus.resp_valid_o,  m_phase == 3);
            chk("resp_data",   bus.resp_data_o,   (m_phase == 3) ? m_resp : 32'd0);
            chk("outstanding", bus.outstanding_o, m_cnt);
            chk("busy",        bus.busy_o,        m_phase != 0);

            case (m_phase)
                0: if (bus.cfg_valid_i) begin m_phase = 1; m_op = bus.cfg_entry_i; end
                1: if (m_cnt == 0 && !m_sat && !bus.sat_valid_i) m_phase = 2;
                2: begin m_phase = 3; m_resp = bus.VCFG_read_data_i; end
                default: if (bus.resp_ready_i) m_phase = 0;
            endcase
            m_sat = mc_inj ? 1'b0 : (m_sat | bus.sat_valid_i);
            m_cnt = m_cnt + (mc_vhs ? 1 : 0) - mc_p;
            if (m_cnt < 0) m_cnt = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.cfg_valid_i      = 1'b0;
        bus.cfg_entry_i      = '0;
        bus.vec_valid_i      = 1'b0;
        bus.retire_i         = '0;
        bus.sat_valid_i      = 1'b0;
        bus.VCFG_read_data_i = '0;
        bus.resp_ready_i     = 1'b0;
    endtask

    initial begin
        quiet();
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        #1;
        chk("lit_reset_busy", bus.busy_o, 0);
        chk("lit_reset_cnt",  bus.outstanding_o, 0);

        // Idle config read: handshake c0, EXEC c2, resp c3, idle c4.
        tick(); bus.cfg_valid_i = 1; bus.cfg_entry_i = mk(CFG_VL_READ, 0);
        bus.VCFG_read_data_i = 32'd16; bus.resp_ready_i = 1;
        #1 chk("lit_rd_cfg_ready", bus.cfg_ready_o, 1);
        tick(); bus.cfg_valid_i = 0;
        #1 chk("lit_rd_c1_vcfg", bus.VCFG_valid_o, 0);
        tick(); #1 chk("lit_rd_c2_vcfg", bus.VCFG_valid_o, 1);
        chk("lit_rd_c2_op", bus.VCFG_entry_o.mode.cfg.csr_op, CFG_VL_READ);
        tick(); #1 chk("lit_rd_c3_rv", bus.resp_valid_o, 1);
        chk("lit_rd_c3_data", bus.resp_data_o, 16);
        tick(); #1 chk("lit_rd_c4_busy", bus.busy_o, 0);
        quiet();

        // Drain wait: 3 vec uops, then VSETVL, retire one per cycle.
        for (int i = 0; i < 3; i++) begin
            tick(); bus.vec_valid_i = 1;
            #1 chk("lit_dr_vec_acc", bus.vec_ready_o, 1);
        end
        tick(); bus.cfg_valid_i = 1; bus.cfg_entry_i = mk(CFG_VSETVL, 32'd20);
        bus.VCFG_read_data_i = 32'd7; bus.resp_ready_i = 1;
        #1 chk("lit_dr_cfg_wins", bus.vec_ready_o, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); bus.cfg_valid_i = 0; bus.retire_i = 2'b01;
            #1 chk("lit_dr_cnt", bus.outstanding_o, 3 - k);
            chk("lit_dr_vcfg", bus.VCFG_valid_o, 0);
            chk("lit_dr_vec_blk", bus.vec_ready_o, 0);
        end
        tick(); bus.retire_i = 0;
        #1 chk("lit_dr_zero", bus.outstanding_o, 0);
        chk("lit_dr_vcfg_z", bus.VCFG_valid_o, 0);
        tick(); #1 chk("lit_dr_exec", bus.VCFG_valid_o, 1);
        tick(); bus.vec_valid_i = 0;
        #1 chk("lit_dr_resp", bus.resp_data_o, 7);
        tick(); #1 chk("lit_dr_idle", bus.busy_o, 0);
        quiet();

        // Full: 8 uops with no retire, then a double retire reopens.
        for (int i = 0; i < 8; i++) begin tick(); bus.vec_valid_i = 1; end
        tick(); #1 chk("lit_full_cnt", bus.outstanding_o, 8);
        chk("lit_full_ready", bus.vec_ready_o, 0);
        bus.vec_valid_i = 0; bus.retire_i = 2'b11;
        #1 chk("lit_full_reopen", bus.vec_ready_o, 1);
        tick(); bus.retire_i = 0;
        #1 chk("lit_full_six", bus.outstanding_o, 6);
        chk("lit_full_ready6", bus.vec_ready_o, 1);
        for (int i = 0; i < 3; i++) begin tick(); bus.retire_i = 2'b11; end
        tick(); bus.retire_i = 0;
        #1 chk("lit_full_drained", bus.outstanding_o, 0);

        // Sat arbitration: sat with the last retire while draining.
        tick(); bus.vec_valid_i = 1;
        tick(); bus.vec_valid_i = 0; bus.cfg_valid_i = 1;
        bus.cfg_entry_i = mk(CFG_CSR_READ, 0); bus.VCFG_read_data_i = 32'hdead_beef;
        bus.resp_ready_i = 1;
        tick(); bus.cfg_valid_i = 0; bus.retire_i = 2'b01; bus.sat_valid_i = 1;
        #1 chk("lit_sat_valid", bus.VCFG_valid_o, 1);
        chk("lit_sat_op", bus.VCFG_entry_o.mode.cfg.csr_op, CFG_VXSAT_SET);
        chk("lit_sat_xval", bus.VCFG_entry_o.rs1.xval, 1);
        tick(); bus.retire_i = 0; bus.sat_valid_i = 0; bus.VCFG_read_data_i = 32'h1234_5678;
        #1 chk("lit_sat_gap", bus.VCFG_valid_o, 0);
        tick(); #1 chk("lit_sat_exec_op", bus.VCFG_entry_o.mode.cfg.csr_op, CFG_CSR_READ);
        tick(); #1 chk("lit_sat_resp", bus.resp_data_o, 32'h1234_5678);
        tick(); quiet();

        // Response backpressure for 5 cycles.
        bus.cfg_valid_i = 1; bus.cfg_entry_i = mk(CFG_CSR_READ, 0);
        bus.VCFG_read_data_i = 32'ha5a5_0001;
        tick(); bus.cfg_valid_i = 0;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            #1 chk("lit_bp_valid", bus.resp_valid_o, 1);
            chk("lit_bp_data", bus.resp_data_o, 32'ha5a5_0001);
            chk("lit_bp_cfg_ready", bus.cfg_ready_o, 0);
            tick();
        end
        bus.resp_ready_i = 1;
        #1 chk("lit_bp_last", bus.resp_valid_o, 1);
        tick(); bus.resp_ready_i = 0;
        #1 chk("lit_bp_idle", bus.cfg_ready_o, 1);

        // Async reset while in EXEC.
        tick(); bus.cfg_valid_i = 1; bus.cfg_entry_i = mk(CFG_VL_READ, 0);
        bus.resp_ready_i = 1;
        tick(); bus.cfg_valid_i = 0;
        tick(); #1 chk("lit_ar_exec", bus.VCFG_valid_o, 1);
        #1 rst_ni = 1'b0;
        #1 chk("lit_ar_vcfg", bus.VCFG_valid_o, 0);
        chk("lit_ar_resp", bus.resp_valid_o, 0);
        chk("lit_ar_cfg_ready", bus.cfg_ready_o, 0);
        chk("lit_ar_cnt", bus.outstanding_o, 0);
        quiet();
        tick(); tick(); rst_ni = 1'b1;
        tick(); #1 chk("lit_ar_after", bus.cfg_ready_o, 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick();
            bus.cfg_valid_i      = ($urandom_range(0, 7) == 0);
            bus.cfg_entry_i      = mk(cfg_csr_op_e'($urandom_range(1, 6)), $urandom);
            bus.vec_valid_i      = ($urandom_range(0, 1) == 0);
            bus.retire_i         = '0;
            if (m_cnt >= 1 && $urandom_range(0, 2) == 0) bus.retire_i[0] = 1'b1;
            if (m_cnt >= 1 + int'(bus.retire_i[0]) && $urandom_range(0, 2) == 0)
                bus.retire_i[1] = 1'b1;
            bus.sat_valid_i      = ($urandom_range(0, 9) == 0);
            bus.resp_ready_i     = ($urandom_range(0, 1) == 0);
            bus.VCFG_read_data_i = $urandom;
        end
        tick(); quiet();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
